velocity_ctrl: RTL and testbench



---
 rtl/velocity_ctrl_pkg.sv | 42 ++++
 rtl/velocity_ctrl_if.sv | 21 ++
 rtl/velocity_ctrl_tick_gen.sv | 20 ++
 rtl/velocity_ctrl.sv | 70 +++++++
 tb/tb_velocity_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/velocity_ctrl_pkg.sv
// Shared definitions for the vehicle speed model: gear codes, per-gear
// speed limits and the velocity controller state encoding.
package velocity_ctrl_pkg;

   localparam logic [2:0] GEAR_N = 3'd0;
   localparam logic [2:0] GEAR_1 = 3'd1;
   localparam logic [2:0] GEAR_2 = 3'd2;
   localparam logic [2:0] GEAR_3 = 3'd3;
   localparam logic [2:0] GEAR_4 = 3'd4;
   localparam logic [2:0] GEAR_5 = 3'd5;
   localparam logic [2:0] GEAR_R = 3'd6;

   localparam logic [7:0] LIM_G1 = 8'd25;
   localparam logic [7:0] LIM_G2 = 8'd45;
   localparam logic [7:0] LIM_G3 = 8'd65;
   localparam logic [7:0] LIM_G4 = 8'd85;
   localparam logic [7:0] LIM_R  = 8'd15;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_ACCEL = 2'd1,
      ST_COAST = 2'd2,
      ST_BRAKE = 2'd3
   } vel_state_t;

   // Top gear runs up to the absolute ceiling; neutral and code 7 allow no drive.
   function automatic logic [7:0] gear_limit(input logic [2:0] g, input logic [7:0] vmax);
      logic [7:0] lim;
      lim = '0;
      case (g)
         GEAR_1:  lim = LIM_G1;
         GEAR_2:  lim = LIM_G2;
         GEAR_3:  lim = LIM_G3;
         GEAR_4:  lim = LIM_G4;
         GEAR_5:  lim = vmax;
         GEAR_R:  lim = LIM_R;
         default: lim = '0;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/velocity_ctrl_if.sv
// Pedal/gear inputs and speed outputs of the velocity controller.
interface velocity_ctrl_if;
   logic       accel;
   logic       brake;
   logic       clutch;
   logic [2:0] gear;
   logic [7:0] velocity_out;
   logic       tick;
   logic [1:0] state;
   logic       overspeed;

   modport master (
      output accel, brake, clutch, gear,
      input  velocity_out, tick, state, overspeed
   );

   modport slave (
      input  accel, brake, clutch, gear,
      output velocity_out, tick, state, overspeed
   );
endinterface

// File: rtl/velocity_ctrl_tick_gen.sv
// Free-running prescaler: pulses tick for one cycle every TICK_DIV clocks,
// first pulse on the TICK_DIV-th cycle after reset.
module tick_gen #(
   parameter int unsigned TICK_DIV = 1000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || tick) count <= '0;
      else             count <= count + CW'(1);
   end
endmodule

// File: rtl/velocity_ctrl.sv
// Vehicle speed integrator: applies brake/drag/accel steps on each prescaled
// tick, clamped to the limit of the gear code fed back from the selector.
module velocity_ctrl
   import velocity_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 1000000,
   parameter int unsigned ACCEL_STEP = 2,
   parameter int unsigned BRAKE_STEP = 5,
   parameter int unsigned DRAG_STEP  = 1,
   parameter int unsigned VMAX       = 120
) (
   input logic            clk,
   input logic            rst,
   velocity_ctrl_if.slave bus
);
   logic       tick;
   logic [7:0] vel;
   vel_state_t st;
   logic [7:0] gmax;
   logic [8:0] v9, gmax9, lim9, inc9, dec_b9, dec_d9, nxt_v;
   vel_state_t nxt_st;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign gmax = gear_limit(bus.gear, 8'(VMAX));

   // All steps are computed one bit wider so neither add nor subtract can wrap.
   always_comb begin
      v9     = {1'b0, vel};
      gmax9  = {1'b0, gmax};
      lim9   = (gmax9 > 9'(VMAX)) ? 9'(VMAX) : gmax9;
      inc9   = v9 + 9'(ACCEL_STEP);
      dec_b9 = (v9 >= 9'(BRAKE_STEP)) ? v9 - 9'(BRAKE_STEP) : '0;
      dec_d9 = (v9 >= 9'(DRAG_STEP))  ? v9 - 9'(DRAG_STEP)  : '0;
      nxt_v  = v9;
      nxt_st = st;
      if (bus.brake) begin
         nxt_v  = dec_b9;
         nxt_st = (dec_b9 == '0) ? ST_STOP : ST_BRAKE;
      end else if (v9 > gmax9) begin
         nxt_v  = (dec_d9 < gmax9) ? gmax9 : dec_d9;
         nxt_st = ST_COAST;
      end else if (bus.accel && !bus.clutch && (gmax != '0)) begin
         nxt_v  = (inc9 > lim9) ? lim9 : inc9;
         nxt_st = ST_ACCEL;
      end else begin
         nxt_v  = dec_d9;
         nxt_st = (dec_d9 == '0) ? ST_STOP : ST_COAST;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vel <= '0;
         st  <= ST_STOP;
      end else if (tick) begin
         vel <= nxt_v[7:0];
         st  <= nxt_st;
      end
   end

   assign bus.velocity_out = vel;
   assign bus.tick         = tick;
   assign bus.state        = st;
   assign bus.overspeed    = (vel > gmax);
endmodule

// File: tb/tb_velocity_ctrl.sv
// Self-checking bench for velocity_ctrl: directed scenarios with literal
// expectations, then random pedals/gears against a behavioural speed model.
module tb_velocity_ctrl;
   localparam int TD   = 4;
   localparam int VMAX = 120;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   velocity_ctrl_if bus ();

   velocity_ctrl #(.TICK_DIV(TD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit armed = 1'b0;

   // Behavioural model: speed, state code and cycles since reset.
   int m_v = 0;
   int m_st = 0;
   int m_cyc = 0;

   function automatic int gmax(input int g);
      int t[8] = '{0, 25, 45, 65, 85, VMAX, 15, 0};
      return t[g];
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      int g;
      g = gmax(int'(bus.gear));
      if (rst) begin
         m_v = 0; m_st = 0; m_cyc = 0;
      end else begin
         if (m_cyc % TD == TD - 1) begin
            if (bus.brake) begin
               m_v = imax(m_v - 5, 0);
               m_st = (m_v == 0) ? 0 : 3;
            end else if (m_v > g) begin
               m_v = imax(m_v - 1, g);
               m_st = 2;
            end else if (bus.accel && !bus.clutch && g > 0) begin
               m_v = imin(imin(m_v + 2, g), VMAX);
               m_st = 1;
            end else begin
               m_v = imax(m_v - 1, 0);
               m_st = (m_v == 0) ? 0 : 2;
            end
         end
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("velocity", int'(bus.velocity_out), m_v);
         check("state", int'(bus.state), m_st);
         check("tick", int'(bus.tick), (m_cyc % TD == TD - 1) ? 1 : 0);
         check("overspeed", int'(bus.overspeed), (m_v > gmax(int'(bus.gear))) ? 1 : 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_in(input bit a, input bit b, input bit c, input int g);
      bus.accel = a; bus.brake = b; bus.clutch = c; bus.gear = 3'(g);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
   endtask

   initial begin
      set_in(0, 0, 0, 0);
      cyc(2);
      do_reset();
      armed = 1'b1;
      check("reset_v", int'(bus.velocity_out), 0);
      check("reset_state", int'(bus.state), 0);
      check("reset_tick", int'(bus.tick), 0);

      // 1: accelerate in first gear up to its limit
      set_in(1, 0, 0, 1);
      cyc(4 * 12);
      check("t1_v24", int'(bus.velocity_out), 24);
      cyc(4);
      check("t1_v25", int'(bus.velocity_out), 25);
      check("t1_model", m_v, 25);
      cyc(8);
      check("t1_hold", int'(bus.velocity_out), 25);
      check("t1_state", int'(bus.state), 1);
      check("t1_ovs", int'(bus.overspeed), 0);

      // 2: brake to standstill
      set_in(0, 1, 0, 1);
      cyc(4);
      check("t2_v20", int'(bus.velocity_out), 20);
      check("t2_st_brake", int'(bus.state), 3);
      cyc(16);
      check("t2_v0", int'(bus.velocity_out), 0);
      check("t2_stop", int'(bus.state), 0);
      set_in(0, 0, 0, 1);
      cyc(8);
      check("t2_hold", int'(bus.velocity_out), 0);

      // 3: clutch pressed coasts, release resumes drive
      set_in(1, 0, 0, 2);
      cyc(4 * 10);
      check("t3_v20", int'(bus.velocity_out), 20);
      set_in(1, 0, 1, 2);
      cyc(4);
      check("t3_coast", int'(bus.velocity_out), 19);
      check("t3_st", int'(bus.state), 2);
      set_in(1, 0, 0, 2);
      cyc(4);
      check("t3_resume", int'(bus.velocity_out), 21);

      // 4: downshift from 100 km/h into second gear
      do_reset();
      set_in(1, 0, 0, 5);
      cyc(4 * 50);
      check("t4_v100", int'(bus.velocity_out), 100);
      set_in(1, 0, 0, 2);
      #1;
      check("t4_ovs_now", int'(bus.overspeed), 1);
      cyc(4 * 54);
      check("t4_v46", int'(bus.velocity_out), 46);
      check("t4_ovs46", int'(bus.overspeed), 1);
      check("t4_st", int'(bus.state), 2);
      cyc(4);
      check("t4_v45", int'(bus.velocity_out), 45);
      check("t4_ovs45", int'(bus.overspeed), 0);
      cyc(8);
      check("t4_hold", int'(bus.velocity_out), 45);

      // 5: both pedals: brake wins
      do_reset();
      set_in(1, 0, 0, 3);
      cyc(4 * 20);
      check("t5_v40", int'(bus.velocity_out), 40);
      set_in(1, 1, 0, 3);
      cyc(4);
      check("t5_v35", int'(bus.velocity_out), 35);
      check("t5_st", int'(bus.state), 3);

      // 6: reset at prescaler count 2 while moving
      do_reset();
      set_in(1, 0, 0, 3);
      cyc(4 * 15);
      check("t6_v30", int'(bus.velocity_out), 30);
      cyc(2);
      do_reset();
      check("t6_v0", int'(bus.velocity_out), 0);
      check("t6_stop", int'(bus.state), 0);
      check("t6_tick0", int'(bus.tick), 0);
      for (int i = 1; i <= 3; i++) begin
         cyc(1);
         check("t6_tick_seq", int'(bus.tick), (i == 3) ? 1 : 0);
      end

      // random pedals, gears and occasional resets
      for (int i = 0; i < 4000; i++) begin
         set_in(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 15), int'($urandom_range(0, 7)));
         rst = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      rst = 1'b0;
      cyc(2);

      armed = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
